// File: rtl/rr_find_first_set.sv
// rr_find_first_set
// Two-stage registered rotating find-first-set. Stage 1 registers the request
// vector and start position; a combinational core picks the first set bit at
// or above the start position (wrapping past the MSB back to bit 0); stage 2
// registers the echoes plus the one-hot, encoded and any-set results.
module rr_find_first_set #(
    parameter  int W  = 32,
    localparam int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          vld_i,
    input  logic [W-1:0]  x_i,
    input  logic [IW-1:0] pos_i,
    output logic          vld_o,
    output logic [W-1:0]  x_o,
    output logic [IW-1:0] pos_o,
    output logic          any_o,
    output logic [W-1:0]  y_o,
    output logic [IW-1:0] y_enc_o
);

    // Isolates the least significant set bit; zero in gives zero out.
    function automatic logic [W-1:0] lowest_set(input logic [W-1:0] v);
        return v & (~v + W'(1));
    endfunction

    // Binary index of a one-hot (or zero) vector; zero maps to index 0.
    function automatic logic [IW-1:0] onehot_to_idx(input logic [W-1:0] oh);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (oh[i]) idx = idx | IW'(i);
        end
        return idx;
    endfunction

    logic          r_vld_p1;
    logic [W-1:0]  r_x_p1;
    logic [IW-1:0] r_pos_p1;

    logic [W-1:0]  w_mask;
    logic [W-1:0]  w_hi;
    logic [W-1:0]  w_src;
    logic [W-1:0]  w_y;
    logic [IW-1:0] w_enc;
    logic          w_any;

    logic          r_vld_p2;
    logic [W-1:0]  r_x_p2;
    logic [IW-1:0] r_pos_p2;
    logic          r_any_p2;
    logic [W-1:0]  r_y_p2;
    logic [IW-1:0] r_enc_p2;

    // ---- stage 1: unconditional input capture ----
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_vld_p1 <= 1'b0;
            r_x_p1   <= '0;
            r_pos_p1 <= '0;
        end else begin
            r_vld_p1 <= vld_i;
            r_x_p1   <= x_i;
            r_pos_p1 <= pos_i;
        end
    end

    // Thermometer-mask search: look among bits >= pos first; if none are set,
    // the wrapped search reduces to the lowest set bit of the whole vector.
    always_comb begin
        w_mask = {W{1'b1}} << r_pos_p1;
        w_hi   = r_x_p1 & w_mask;
        w_src  = (|w_hi) ? w_hi : r_x_p1;
        w_y    = lowest_set(w_src);
        w_enc  = onehot_to_idx(w_y);
        w_any  = |r_x_p1;
    end

    // ---- stage 2: result and echo registers driving the outputs ----
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_vld_p2 <= 1'b0;
            r_x_p2   <= '0;
            r_pos_p2 <= '0;
            r_any_p2 <= 1'b0;
            r_y_p2   <= '0;
            r_enc_p2 <= '0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            r_x_p2   <= r_x_p1;
            r_pos_p2 <= r_pos_p1;
            r_any_p2 <= w_any;
            r_y_p2   <= w_y;
            r_enc_p2 <= w_enc;
        end
    end

    assign vld_o   = r_vld_p2;
    assign x_o     = r_x_p2;
    assign pos_o   = r_pos_p2;
    assign any_o   = r_any_p2;
    assign y_o     = r_y_p2;
    assign y_enc_o = r_enc_p2;

endmodule

// File: tb/tb_rr_find_first_set.sv
// Bench for rr_find_first_set at W=8: directed literal vectors, exhaustive
// sweep, random streaming and an asynchronous mid-stream reset, with a
// behavioural reference checked on every falling clock edge.
module tb_rr_find_first_set;

    localparam int W  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          vld_i;
    logic [W-1:0]  x_i;
    logic [IW-1:0] pos_i;
    logic          vld_o;
    logic [W-1:0]  x_o;
    logic [IW-1:0] pos_o;
    logic          any_o;
    logic [W-1:0]  y_o;
    logic [IW-1:0] y_enc_o;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    rr_find_first_set #(.W(W)) dut (
        .clk(clk), .arst_n(arst_n), .vld_i(vld_i), .x_i(x_i), .pos_i(pos_i),
        .vld_o(vld_o), .x_o(x_o), .pos_o(pos_o), .any_o(any_o),
        .y_o(y_o), .y_enc_o(y_enc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk the indices in priority order pos, pos+1, ... (mod W).
    function automatic void model(input logic [W-1:0] x, input int pos,
                                  output logic any, output logic [W-1:0] y,
                                  output logic [IW-1:0] enc);
        any = 1'b0; y = '0; enc = '0;
        for (int i = 0; i < W; i++) begin
            int k;
            k = (pos + i) % W;
            if (!any && x[k]) begin
                any = 1'b1;
                y   = W'(1) << k;
                enc = IW'(k);
            end
        end
    endfunction

    // Two-cycle history of what the inputs were at each rising edge.
    logic          h1_vld, h2_vld;
    logic [W-1:0]  h1_x, h2_x;
    logic [IW-1:0] h1_pos, h2_pos;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            h1_vld <= 0; h1_x <= 0; h1_pos <= 0;
            h2_vld <= 0; h2_x <= 0; h2_pos <= 0;
        end else begin
            h1_vld <= vld_i; h1_x <= x_i; h1_pos <= pos_i;
            h2_vld <= h1_vld; h2_x <= h1_x; h2_pos <= h1_pos;
        end
    end

    // Compare the outputs against the reference and invariants every cycle.
    always @(negedge clk) begin
        if (started) begin
            logic          e_any;
            logic [W-1:0]  e_y;
            logic [IW-1:0] e_enc;
            model(h2_x, int'(h2_pos), e_any, e_y, e_enc);
            chk("vld_o", vld_o, h2_vld);
            chk("x_o", x_o, h2_x);
            chk("pos_o", pos_o, h2_pos);
            chk("any_o", any_o, e_any);
            chk("y_o", y_o, e_y);
            chk("y_enc_o", y_enc_o, e_enc);
            chk("popcount", $countones(y_o), any_o);
            if (any_o) begin
                chk("y_vs_enc", y_o, W'(1) << y_enc_o);
                chk("x_at_enc", x_o[y_enc_o], 1);
            end
        end
    end

    // Drive one vector, let it travel through both stages, check literals.
    task automatic dir(input string name, input logic [W-1:0] x, input logic [IW-1:0] p,
                       input logic ea, input logic [W-1:0] ey, input logic [IW-1:0] ee);
        @(negedge clk);
        vld_i = 1'b1; x_i = x; pos_i = p;
        @(posedge clk); @(posedge clk); #1;
        chk({name, ".any"}, any_o, ea);
        chk({name, ".y"}, y_o, ey);
        chk({name, ".enc"}, y_enc_o, ee);
    endtask

    initial begin
        logic          m_any;
        logic [W-1:0]  m_y;
        logic [IW-1:0] m_enc;

        // Pin the reference itself on hand-computed cases.
        model(8'h24, 6, m_any, m_y, m_enc);
        chk("model.wrap", {m_any, m_y, 5'(m_enc)}, {1'b1, 8'h04, 5'd2});
        model(8'h10, 5, m_any, m_y, m_enc);
        chk("model.lastprio", {m_any, m_y, 5'(m_enc)}, {1'b1, 8'h10, 5'd4});
        model(8'h00, 3, m_any, m_y, m_enc);
        chk("model.empty", {m_any, m_y, 5'(m_enc)}, 14'd0);

        arst_n = 1'b0; vld_i = 1'b1; x_i = 8'hFF; pos_i = 3'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.vld", vld_o, 0);
        chk("rst.any", any_o, 0);
        chk("rst.x", x_o, 0);
        chk("rst.pos", pos_o, 0);
        chk("rst.y", y_o, 0);
        chk("rst.enc", y_enc_o, 0);

        @(negedge clk);
        arst_n = 1'b1; vld_i = 1'b0; x_i = '0; pos_i = '0;
        started = 1;
        @(negedge clk);
        vld_i = 1'b1;
        @(posedge clk); #1;
        chk("lat.edgeN", vld_o, 0);
        @(negedge clk); vld_i = 1'b0;
        @(posedge clk); #1;
        chk("lat.edgeN1", vld_o, 1);

        dir("p3", 8'h24, 3'd3, 1, 8'h20, 3'd5);
        dir("p2incl", 8'h24, 3'd2, 1, 8'h04, 3'd2);
        dir("wrap6", 8'h24, 3'd6, 1, 8'h04, 3'd2);
        dir("wrap7", 8'h01, 3'd7, 1, 8'h01, 3'd0);
        dir("msb0", 8'h80, 3'd0, 1, 8'h80, 3'd7);
        dir("lowprio", 8'h08, 3'd4, 1, 8'h08, 3'd3);
        dir("empty", 8'h00, 3'd5, 0, 8'h00, 3'd0);
        for (int p = 0; p < W; p++)
            dir("full", 8'hFF, IW'(p), 1, W'(1) << p, IW'(p));

        // Exhaustive sweep, one vector per cycle.
        for (int x = 0; x < 256; x++) begin
            for (int p = 0; p < W; p++) begin
                @(negedge clk);
                vld_i = x[0] ^ p[0]; x_i = W'(x); pos_i = IW'(p);
            end
        end

        // Random streaming with an asynchronous reset pulse in the middle.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            vld_i = 1'($urandom); x_i = W'($urandom); pos_i = IW'($urandom);
            if (i == 150) begin
                x_i = 8'hA5; vld_i = 1'b1;
                @(posedge clk); #2;
                arst_n = 1'b0;
                #1;
                chk("mid.vld", vld_o, 0);
                chk("mid.x", x_o, 0);
                chk("mid.y", y_o, 0);
                chk("mid.any", any_o, 0);
                @(posedge clk); #3;
                arst_n = 1'b1;
                @(negedge clk);
                vld_i = 1'b1; x_i = 8'h10; pos_i = 3'd6;
                @(posedge clk); #1;
                chk("post.edge1", vld_o, 0);
                @(negedge clk); vld_i = 1'b0; x_i = 8'h00;
                @(posedge clk); #1;
                chk("post.edge2.vld", vld_o, 1);
                chk("post.edge2.y", y_o, 8'h10);
                chk("post.edge2.enc", y_enc_o, 3'd4);
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
